// File: rtl/axis_adder.sv
//==============================================================================
// Module      : axis_adder
// Description : Two-stream AXI-Stream joining adder with a DEPTH-entry result
//               buffer. Define AXIS_ADDER_CNT_EN to add the trans_cnt_o counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module axis_adder #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s1_valid_i,
    output logic             s1_ready_o,
    input  logic [WIDTH-1:0] s1_data_i,
    input  logic             s2_valid_i,
    output logic             s2_ready_o,
    input  logic [WIDTH-1:0] s2_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
`ifdef AXIS_ADDER_CNT_EN
    output logic [WIDTH:0]   m_data_o,
    output logic [15:0]      trans_cnt_o
`else
    output logic [WIDTH:0]   m_data_o
`endif
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [WIDTH:0]       r_mem [DEPTH];

    logic w_full;
    logic w_fire;
    logic w_pop;

    // Readys depend only on partner valid, registered state and reset, so
    // m_ready_i never reaches them combinationally.
    assign w_full     = (r_state == S_FULL);
    assign s1_ready_o = s2_valid_i & ~w_full & ~reset;
    assign s2_ready_o = s1_valid_i & ~w_full & ~reset;
    assign w_fire     = s1_valid_i & s2_valid_i & ~w_full & ~reset;
    assign m_valid_o  = (r_count != '0);
    assign w_pop      = m_valid_o & m_ready_i;
    assign m_data_o   = m_valid_o ? r_mem[r_rd_ptr] : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY:   if (w_fire) w_state_nxt = S_PARTIAL;
            S_PARTIAL: begin
                if (w_fire && !w_pop && r_count == c_cnt_last)
                    w_state_nxt = S_FULL;
                else if (w_pop && !w_fire && r_count == c_cnt_one)
                    w_state_nxt = S_EMPTY;
            end
            S_FULL:    if (w_pop) w_state_nxt = S_PARTIAL;
            default:   w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_EMPTY;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= r_count + c_cnt_w'(w_fire) - c_cnt_w'(w_pop);
            if (w_fire) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        end
    end

    // Storage needs no reset: entries are only visible behind a valid count.
    always_ff @(posedge clk) begin
        if (w_fire)
            r_mem[r_wr_ptr] <= {1'b0, s1_data_i} + {1'b0, s2_data_i};
    end

`ifdef AXIS_ADDER_CNT_EN
    logic [15:0] r_trans_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_trans_cnt <= '0;
        else if (w_pop)
            r_trans_cnt <= r_trans_cnt + 16'd1;
    end

    assign trans_cnt_o = r_trans_cnt;
`endif

endmodule

`default_nettype wire
